// File: rtl/spi_regbank_pkg.sv
// Shared types and constants for the SPI register-bank slave.
package spi_regbank_pkg;

  // Transaction state: waiting for CS, shifting the command byte, shifting data words.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam int CMD_WIDTH  = 8;
  localparam int ADDR_WIDTH = 7;
  localparam int RW_BIT     = 7;

  // Burst address step: wraps to 0 after the last mapped register. An
  // unmapped start address simply walks up and wraps at the 7-bit limit.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input int total);
    if (int'(a) == total - 1) return '0;
    return a + ADDR_WIDTH'(1);
  endfunction

endpackage

// File: rtl/spi_clk_edge.sv
// SPI clock edge detector: turns the synchronised spi_clk into one-cycle
// sample/shift strobes according to {cpol,cpha}.
module spi_clk_edge
  import spi_regbank_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ena,
  input  logic i_spi_clk,
  input  logic i_cpol,
  input  logic i_cpha,
  output logic o_sample_stb,
  output logic o_shift_stb
);

  logic r_prev;
  logic r_sample;
  logic r_shift;
  logic w_lead;
  logic w_trail;

  // Leading edge moves away from the idle level, trailing edge returns to it.
  assign w_lead  = (r_prev == i_cpol) && (i_spi_clk != i_cpol);
  assign w_trail = (r_prev != i_cpol) && (i_spi_clk == i_cpol);

  // Register the edge decode; CPHA selects which edge samples and which shifts.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev   <= 1'b0;
      r_sample <= 1'b0;
      r_shift  <= 1'b0;
    end else if (i_ena) begin
      r_prev   <= i_spi_clk;
      r_sample <= i_cpha ? w_trail : w_lead;
      r_shift  <= i_cpha ? w_lead  : w_trail;
    end else begin
      r_sample <= 1'b0;
      r_shift  <= 1'b0;
    end
  end

  assign o_sample_stb = r_sample & i_ena;
  assign o_shift_stb  = r_shift  & i_ena;

endmodule

// File: rtl/spi_regbank_slave.sv
// SPI slave in front of a config (R/W) + status (RO) register bank with
// burst auto-increment, per-register write pulses and aborted-frame detection.
module spi_regbank_slave
  import spi_regbank_pkg::*;
#(
  parameter int NUM_CFG    = 8,
  parameter int NUM_STATUS = 8,
  parameter int REG_WIDTH  = 8,
  parameter logic [NUM_CFG*REG_WIDTH-1:0] CFG_RESET = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               ena,
  input  logic [1:0]                         mode,
  input  logic                               spi_cs_n,
  input  logic                               spi_clk,
  input  logic                               spi_mosi,
  output logic                               spi_miso,
  output logic                               spi_miso_oe,
  output logic [NUM_CFG*REG_WIDTH-1:0]       config_regs,
  input  logic [((NUM_STATUS > 0) ? NUM_STATUS : 1)*REG_WIDTH-1:0] status_regs,
  output logic [NUM_CFG-1:0]                 cfg_wr_pulse,
  output logic                               busy,
  output logic                               frame_err
);

  localparam int TOTAL = NUM_CFG + NUM_STATUS;
  localparam int CW    = $clog2(REG_WIDTH + 1);

  state_e                  r_state;
  logic                    r_cs_prev;
  logic [1:0]              r_mode;
  logic [CW-1:0]           r_bitcnt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_wr;
  logic [REG_WIDTH-2:0]    r_rx;
  logic [REG_WIDTH-1:0]    r_tx;
  logic                    r_skip;
  logic [REG_WIDTH-1:0]    r_cfg [NUM_CFG];
  logic [NUM_CFG-1:0]      r_pulse;
  logic                    r_ferr;
  logic                    r_busy;
  logic                    r_oe;

  logic                    w_sample;
  logic                    w_shift;
  logic                    w_cs_fall;
  logic                    w_cs_rise;
  logic [REG_WIDTH-1:0]    w_rx_next;
  logic [CMD_WIDTH-1:0]    w_cmd_byte;
  logic                    w_cmd_done;
  logic                    w_frame_done;
  logic [ADDR_WIDTH-1:0]   w_load_addr;
  logic                    w_load_wr;
  logic [REG_WIDTH-1:0]    w_rd_data;

  spi_clk_edge u_edge (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_ena        (ena),
    .i_spi_clk    (spi_clk),
    .i_cpol       (r_mode[1]),
    .i_cpha       (r_mode[0]),
    .o_sample_stb (w_sample),
    .o_shift_stb  (w_shift)
  );

  // r_cs_prev resets to "low" so a CS held low across reset is not a fresh fall.
  assign w_cs_fall = r_cs_prev & ~spi_cs_n;
  assign w_cs_rise = ~r_cs_prev & spi_cs_n;

  assign w_rx_next  = {r_rx, spi_mosi};
  assign w_cmd_byte = w_rx_next[CMD_WIDTH-1:0];

  // A CS rise in the same cycle as a sample strobe wins: the strobe is dropped.
  assign w_cmd_done   = w_sample && !w_cs_rise && (r_state == CMD) &&
                        (r_bitcnt == CW'(CMD_WIDTH - 1));
  assign w_frame_done = w_sample && !w_cs_rise && (r_state == DATA) &&
                        (r_bitcnt == CW'(REG_WIDTH - 1));

  // Address (and direction) of the word whose frame starts after this boundary.
  assign w_load_addr = (r_state == CMD) ? w_cmd_byte[ADDR_WIDTH-1:0]
                                        : next_addr(r_addr, TOTAL);
  assign w_load_wr   = (r_state == CMD) ? w_cmd_byte[RW_BIT] : r_wr;

  // Read mux for the tx snapshot; unmapped addresses read as zero.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_CFG; i++)
      if (int'(w_load_addr) == i) w_rd_data = r_cfg[i];
    for (int i = 0; i < NUM_STATUS; i++)
      if (int'(w_load_addr) == NUM_CFG + i) w_rd_data = status_regs[i*REG_WIDTH +: REG_WIDTH];
  end

  // Transaction FSM, bit counter, address and rx/tx shift registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cs_prev <= 1'b0;
      r_mode    <= 2'b00;
      r_bitcnt  <= '0;
      r_addr    <= '0;
      r_wr      <= 1'b0;
      r_rx      <= '0;
      r_tx      <= '0;
      r_skip    <= 1'b0;
      r_ferr    <= 1'b0;
      r_busy    <= 1'b0;
      r_oe      <= 1'b0;
    end else if (ena) begin
      r_cs_prev <= spi_cs_n;
      r_busy    <= ~spi_cs_n;
      r_oe      <= ~spi_cs_n;
      r_ferr    <= 1'b0;
      if (w_cs_rise) begin
        if (r_state != IDLE) r_ferr <= (r_bitcnt != '0);
        r_state  <= IDLE;
        r_bitcnt <= '0;
      end else if (w_cs_fall && r_state == IDLE) begin
        // Mode is frozen for the whole transaction; MISO idles low until a read load.
        r_state  <= CMD;
        r_mode   <= mode;
        r_bitcnt <= '0;
        r_tx     <= '0;
        r_skip   <= 1'b0;
      end else if (r_state != IDLE) begin
        if (w_sample) begin
          r_rx <= w_rx_next[REG_WIDTH-2:0];
          if (w_cmd_done || w_frame_done) begin
            r_state  <= DATA;
            r_bitcnt <= '0;
            r_addr   <= w_load_addr;
            if (w_cmd_done) r_wr <= w_cmd_byte[RW_BIT];
            // Writes keep MISO at zero; reads snapshot the next register.
            r_tx     <= w_load_wr ? '0 : w_rd_data;
            r_skip   <= 1'b1;
          end else begin
            r_bitcnt <= r_bitcnt + CW'(1);
          end
        end else if (w_shift) begin
          // The first shift edge after a load would drop the MSB before the master sees it.
          if (r_skip) r_skip <= 1'b0;
          else        r_tx   <= r_tx << 1;
        end
      end
    end else begin
      r_ferr <= 1'b0;
    end
  end

  // Config bank: commit a completed write frame and raise its one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CFG; i++) r_cfg[i] <= CFG_RESET[i*REG_WIDTH +: REG_WIDTH];
      r_pulse <= '0;
    end else if (ena) begin
      r_pulse <= '0;
      if (w_frame_done && r_wr) begin
        for (int i = 0; i < NUM_CFG; i++) begin
          if (int'(r_addr) == i) begin
            r_cfg[i]   <= w_rx_next;
            r_pulse[i] <= 1'b1;
          end
        end
      end
    end else begin
      r_pulse <= '0;
    end
  end

  for (genvar g = 0; g < NUM_CFG; g++) begin : g_pack
    assign config_regs[g*REG_WIDTH +: REG_WIDTH] = r_cfg[g];
  end

  assign spi_miso     = r_tx[REG_WIDTH-1];
  assign spi_miso_oe  = r_oe;
  assign busy         = r_busy;
  assign cfg_wr_pulse = r_pulse & {NUM_CFG{ena}};
  assign frame_err    = r_ferr & ena;

endmodule

// File: tb/tb_spi_regbank_slave.sv
// Randomised + directed bench: two slaves (8x8-bit+8 status, 4x16-bit+2 status)
// share SPI clock/data lines with separate chip selects, checked against a
// transaction-level register model.
module tb_spi_regbank_slave;

  localparam int H = 4;
  localparam logic [63:0] RST_A = 64'h8877665544332211;
  localparam logic [63:0] RST_B = 64'hDDDDCCCCBBBBAAAA;

  logic clk = 1'b0;
  logic rst, ena, sclk, mosi, cs_a, cs_b;
  logic [1:0] mode;
  logic miso_a, oe_a, busy_a, ferr_a, miso_b, oe_b, busy_b, ferr_b;
  logic [63:0] cfg_a, cfg_b, st_a;
  logic [31:0] st_b;
  logic [7:0] pulse_a;
  logic [3:0] pulse_b;

  always #5 clk = ~clk;

  spi_regbank_slave #(.NUM_CFG(8), .NUM_STATUS(8), .REG_WIDTH(8), .CFG_RESET(RST_A)) dut_a (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode), .spi_cs_n(cs_a), .spi_clk(sclk),
    .spi_mosi(mosi), .spi_miso(miso_a), .spi_miso_oe(oe_a), .config_regs(cfg_a),
    .status_regs(st_a), .cfg_wr_pulse(pulse_a), .busy(busy_a), .frame_err(ferr_a));

  spi_regbank_slave #(.NUM_CFG(4), .NUM_STATUS(2), .REG_WIDTH(16), .CFG_RESET(RST_B)) dut_b (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode), .spi_cs_n(cs_b), .spi_clk(sclk),
    .spi_mosi(mosi), .spi_miso(miso_b), .spi_miso_oe(oe_b), .config_regs(cfg_b),
    .status_regs(st_b), .cfg_wr_pulse(pulse_b), .busy(busy_b), .frame_err(ferr_b));

  int n_chk = 0;
  int n_err = 0;
  int pc[2][8];
  int fe[2];
  logic [15:0] m_cfg[2][8];
  logic [15:0] wdata[4];
  logic [15:0] rd_q[$];
  int cur_sel;
  logic cpol_c, cpha_c;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int ncfg(input int s); return s ? 4 : 8; endfunction
  function automatic int tot(input int s);  return s ? 6 : 16; endfunction
  function automatic int wid(input int s);  return s ? 16 : 8; endfunction

  function automatic logic [15:0] model_read(input int s, input int a);
    if (a < ncfg(s)) return m_cfg[s][a];
    if (a < tot(s)) return s ? st_b[(a-4)*16 +: 16] : {8'h00, st_a[(a-8)*8 +: 8]};
    return 16'h0;
  endfunction

  function automatic logic [63:0] mpack(input int s);
    logic [63:0] v = '0;
    for (int i = 0; i < ncfg(s); i++) begin
      if (s == 0) v[i*8 +: 8] = m_cfg[0][i][7:0];
      else        v[i*16 +: 16] = m_cfg[1][i];
    end
    return v;
  endfunction

  task automatic reset_model();
    logic [63:0] ra, rb;
    ra = RST_A; rb = RST_B;
    for (int i = 0; i < 8; i++) m_cfg[0][i] = {8'h00, ra[i*8 +: 8]};
    for (int i = 0; i < 4; i++) m_cfg[1][i] = rb[i*16 +: 16];
  endtask

  task automatic wt(input int n); repeat (n) @(negedge clk); endtask

  // One SPI bit as the master sees it: drive MOSI, read MISO at the sampling edge.
  task automatic xbit(input logic b, output logic r);
    if (!cpha_c) begin
      mosi = b; wt(H);
      r = cur_sel ? miso_b : miso_a;
      sclk = ~cpol_c; wt(H);
      sclk = cpol_c;
    end else begin
      sclk = ~cpol_c; mosi = b; wt(H);
      r = cur_sel ? miso_b : miso_a;
      sclk = cpol_c; wt(H);
    end
  endtask

  task automatic cs_begin(input int s, input logic [1:0] md);
    cur_sel = s; cpol_c = md[1]; cpha_c = md[0];
    mode = md; sclk = md[1]; wt(4);
    if (s) cs_b = 1'b0; else cs_a = 1'b0;
    wt(3);
    mode = 2'($urandom);   // must be ignored until the next CS fall
    wt(1);
  endtask

  task automatic cs_end();
    wt(3); cs_a = 1'b1; cs_b = 1'b1; wt(4); mosi = 1'b0;
  endtask

  task automatic do_txn(input int s, input logic [1:0] md, input logic wr, input int addr,
                        input int nw, input int part, input int cmd_bits);
    int a, fe0;
    int pc0[8], ep[8];
    logic r;
    logic [7:0] cmd, rc;
    logic [15:0] w, rw, ex;
    for (int i = 0; i < 8; i++) begin pc0[i] = pc[s][i]; ep[i] = 0; end
    fe0 = fe[s];
    rd_q.delete();
    cs_begin(s, md);
    cmd = {wr, 7'(addr)};
    rc = '0;
    for (int i = 0; i < cmd_bits; i++) begin xbit(cmd[7-i], r); rc = {rc[6:0], r}; end
    chk("cmd_miso_zero", {56'h0, rc}, 64'h0);
    if (cmd_bits == 8) begin
      a = addr;
      for (int k = 0; k < nw; k++) begin
        w = wr ? wdata[k] : 16'($urandom);
        rw = '0;
        for (int i = wid(s) - 1; i >= 0; i--) begin xbit(w[i], r); rw = {rw[14:0], r}; end
        ex = wr ? 16'h0 : model_read(s, a);
        chk("miso_word", {48'h0, rw}, {48'h0, ex});
        rd_q.push_back(rw);
        if (wr && a < ncfg(s)) begin
          m_cfg[s][a] = s ? w : {8'h00, w[7:0]};
          ep[a]++;
        end
        a = (a == tot(s) - 1) ? 0 : (a + 1) % 128;
      end
      if (part > 0) begin
        rw = '0;
        for (int i = 0; i < part; i++) begin xbit(1'($urandom), r); rw = {rw[14:0], r}; end
        ex = wr ? 16'h0 : (model_read(s, a) >> (wid(s) - part));
        chk("miso_partial", {48'h0, rw}, {48'h0, ex});
      end
    end
    cs_end();
    chk("frame_err_cnt", 64'(fe[s] - fe0),
        ((cmd_bits > 0 && cmd_bits < 8) || (cmd_bits == 8 && part > 0)) ? 64'd1 : 64'd0);
    for (int i = 0; i < ncfg(s); i++) chk("wr_pulse_cnt", 64'(pc[s][i] - pc0[i]), 64'(ep[i]));
    chk("config_bank", s ? cfg_b : cfg_a, mpack(s));
  endtask

  // Per-cycle checks: busy/oe follow CS one cycle late (held while ena=0),
  // at most one write pulse; also counts pulses for the transaction checks.
  task automatic monitor();
    logic eb[2];
    logic vld, rc, ec;
    logic [1:0] cc;
    vld = 1'b0;
    forever begin
      @(posedge clk);
      rc = rst; ec = ena; cc = {cs_b, cs_a};
      #1;
      if (rc) begin eb[0] = 1'b0; eb[1] = 1'b0; vld = 1'b1; end
      else if (ec) begin eb[0] = ~cc[0]; eb[1] = ~cc[1]; end
      if (vld) begin
        chk("busy_a", {63'h0, busy_a}, {63'h0, eb[0]});
        chk("oe_a",   {63'h0, oe_a},   {63'h0, eb[0]});
        chk("busy_b", {63'h0, busy_b}, {63'h0, eb[1]});
        chk("oe_b",   {63'h0, oe_b},   {63'h0, eb[1]});
        chk("pulse_onehot", {62'h0, ($countones(pulse_a) <= 1), ($countones(pulse_b) <= 1)}, 64'h3);
      end
      if (ferr_a) fe[0]++;
      if (ferr_b) fe[1]++;
      for (int i = 0; i < 8; i++) if (pulse_a[i]) pc[0][i]++;
      for (int i = 0; i < 4; i++) if (pulse_b[i]) pc[1][i]++;
    end
  endtask

  initial begin
    int s;
    for (int i = 0; i < 8; i++) begin pc[0][i] = 0; pc[1][i] = 0; end
    fe[0] = 0; fe[1] = 0;
    rst = 1'b1; ena = 1'b1; cs_a = 1'b1; cs_b = 1'b1; sclk = 1'b0; mosi = 1'b0; mode = 2'b00;
    st_a = 64'h0123456789ABCDCA;
    st_b = {16'h1234, 16'h5678};
    reset_model();
    fork monitor(); join_none
    wt(3);
    // Reset state
    chk("rst_cfg_a", cfg_a, 64'h8877665544332211);
    chk("rst_cfg_b", cfg_b, 64'hDDDDCCCCBBBBAAAA);
    chk("rst_outs_a", {58'h0, miso_a, oe_a, busy_a, ferr_a, |pulse_a, 1'b0}, 64'h0);
    chk("rst_outs_b", {58'h0, miso_b, oe_b, busy_b, ferr_b, |pulse_b, 1'b0}, 64'h0);
    rst = 1'b0; wt(3);

    // Mode 0 single write
    wdata[0] = 16'h00A5;
    do_txn(0, 2'b00, 1'b1, 3, 1, 0, 8);
    chk("lit_reg3", {56'h0, cfg_a[31:24]}, 64'hA5);

    // Status read in modes 1..3
    for (int m = 1; m < 4; m++) begin
      do_txn(0, 2'(m), 1'b0, 8, 1, 0, 8);
      chk("lit_status0", {48'h0, rd_q[0]}, 64'hCA);
    end

    // Burst write spilling into status space
    wdata[0] = 16'h11; wdata[1] = 16'h22; wdata[2] = 16'h33;
    do_txn(0, 2'b00, 1'b1, 6, 3, 0, 8);
    chk("lit_reg6", {56'h0, cfg_a[55:48]}, 64'h11);
    chk("lit_reg7", {56'h0, cfg_a[63:56]}, 64'h22);

    // 16-bit burst read wrapping from last status to config 0
    do_txn(1, 2'b11, 1'b0, 5, 2, 0, 8);
    chk("lit_wrap0", {48'h0, rd_q[0]}, 64'h1234);
    chk("lit_wrap1", {48'h0, rd_q[1]}, 64'hAAAA);

    // Aborted write frame
    wdata[0] = 16'hFF;
    do_txn(0, 2'b00, 1'b1, 2, 0, 5, 8);
    chk("lit_reg2_kept", {56'h0, cfg_a[23:16]}, 64'h33);

    // Reset in the middle of a read
    begin
      logic r;
      cs_begin(0, 2'b01);
      for (int i = 0; i < 8; i++) xbit(i == 4, r);   // read addr 0x08
      for (int i = 0; i < 3; i++) xbit(1'b1, r);
      rst = 1'b1; wt(1);
      chk("midrst_outs", {59'h0, miso_a, oe_a, busy_a, ferr_a, |pulse_a}, 64'h0);
      chk("midrst_cfg", cfg_a, 64'h8877665544332211);
      rst = 1'b0; cs_a = 1'b1; sclk = 1'b0; mosi = 1'b0;
      reset_model(); wt(4);
      wdata[0] = 16'h5A;
      do_txn(0, 2'b00, 1'b1, 1, 1, 0, 8);
      chk("lit_reg1_after_rst", {56'h0, cfg_a[15:8]}, 64'h5A);
    end

    // Enable low: CS activity is invisible
    ena = 1'b0; wt(2); cs_a = 1'b0; wt(3);
    chk("ena_hold_busy", {63'h0, busy_a}, 64'h0);
    cs_a = 1'b1; wt(2); ena = 1'b1; wt(3);

    // Random traffic
    for (int it = 0; it < 40; it++) begin
      int ad, nw, pt, cb;
      s = int'($urandom % 2);
      st_a = {$urandom, $urandom};
      st_b = $urandom;
      for (int k = 0; k < 4; k++) wdata[k] = 16'($urandom);
      ad = ($urandom % 5 == 0) ? int'($urandom % 128) : int'($urandom % (tot(s) + 1));
      nw = int'($urandom % 4);
      pt = ($urandom % 4 == 0) ? 1 + int'($urandom % (wid(s) - 1)) : 0;
      cb = ($urandom % 8 == 0) ? int'($urandom % 8) : 8;
      do_txn(s, 2'($urandom), 1'($urandom), ad, nw, pt, cb);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
